rr_packet_arbiter: RTL



---
 rtl/rr_pkg.sv | 36 +++
 rtl/rr_pick_comb.sv | 22 ++
 rtl/rr_packet_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared types and the rotating-priority pick function for the packet arbiter.
package rr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                 any;
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_REQ-1:0]   onehot;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1, ... wrapping modulo num_req.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_IDX_W-1:0] ptr,
                                    input int                   num_req);
    pick_t                res;
    logic [MAX_IDX_W-1:0] k;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = MAX_IDX_W'((int'(ptr) + i) % num_req);
      if (i < num_req && !res.any && req[k]) begin
        res.any       = 1'b1;
        res.idx       = k;
        res.onehot[k] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotating-priority picker; one-hot and index of the winner.
module rr_pick_comb
  import rr_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx
);

  pick_t w_pick;

  assign w_pick   = rr_pick(MAX_REQ'(i_req), MAX_IDX_W'(i_ptr), NUM_REQ);
  assign o_any    = w_pick.any;
  assign o_onehot = NUM_REQ'(w_pick.onehot);
  assign o_idx    = IDX_W'(w_pick.idx);

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grant held from first beat to last beat.
// Define RR_BACK2BACK_EN to re-arbitrate on the last beat with no idle bubble.
module rr_packet_arbiter
  import rr_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [IDX_W-1:0]          out_src_o,
  output logic                      busy_o
);

  state_e             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_src;
  logic [IDX_W-1:0]   r_ptr;

  logic               w_busy;
  logic               w_xfer_last;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [IDX_W-1:0]   w_pick_ptr;
  logic               w_pick_any;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;

  assign w_busy     = (r_state == BURST);
  assign w_ptr_next = (r_src == IDX_W'(NUM_REQ - 1)) ? '0 : r_src + 1'b1;

`ifdef RR_BACK2BACK_EN
  // In BURST the picker only matters on the last beat, where priority has already moved on.
  assign w_pick_ptr = w_busy ? w_ptr_next : r_ptr;
`else
  assign w_pick_ptr = r_ptr;
`endif

  rr_pick_comb #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (req_valid_i),
    .i_ptr    (w_pick_ptr),
    .o_any    (w_pick_any),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    req_ready_o = '0;
    if (w_busy) begin
      out_valid_o = req_valid_i[r_src];
      out_data_o  = req_data_i[r_src*DATA_W +: DATA_W];
      out_last_o  = req_last_i[r_src];
      req_ready_o = r_gnt & {NUM_REQ{out_ready_i}};
    end
  end

  assign w_xfer_last = out_valid_o & out_ready_i & out_last_o;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_gnt   <= w_pick_onehot;
            r_src   <= w_pick_idx;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_xfer_last) begin
            r_ptr <= w_ptr_next;
`ifdef RR_BACK2BACK_EN
            if (w_pick_any) begin
              r_gnt <= w_pick_onehot;
              r_src <= w_pick_idx;
            end else begin
              r_gnt   <= '0;
              r_state <= IDLE;
            end
`else
            r_gnt   <= '0;
            r_state <= IDLE;
`endif
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign out_src_o = r_src;
  assign busy_o    = w_busy;

endmodule
